// File: rtl/nes_cpu_bus_initiator.sv
// Famicom/NES CPU bus-cycle initiator: free-running M2 cycles, a one-deep request
// buffer with boundary bypass, and idle reads at $0000 when nothing is queued.
module nes_cpu_bus_initiator #(
  parameter int M2_LOW  = 5,
  parameter int M2_HIGH = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  input  logic        irq_n,
  output logic        irq_pending
);
  localparam int PH_MAX = (M2_LOW > M2_HIGH) ? M2_LOW : M2_HIGH;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(M2_LOW - 1);
  localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(M2_HIGH - 1);
  localparam logic ST_LOW  = 1'b0;
  localparam logic ST_HIGH = 1'b1;

  logic            state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic            hold_full_q, hold_full_d, hold_rw_q, hold_rw_d;
  logic [15:0]     hold_addr_q, hold_addr_d;
  logic [7:0]      hold_wdata_q, hold_wdata_d;
  logic            cur_req_q, cur_req_d, cur_rw_q, cur_rw_d;
  logic [15:0]     cur_addr_q, cur_addr_d;
  logic [7:0]      cur_wdata_q, cur_wdata_d;
  logic            m2_q, m2_d, romsel_q, romsel_d, bus_rw_q, bus_rw_d;
  logic [15:0]     bus_addr_q, bus_addr_d;
  logic [7:0]      dout_q, dout_d;
  logic            oe_q, oe_d, rsp_v_q, rsp_v_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            irq_s1_q, irq_s2_q;
  logic            accept, low0, low_last, boundary;

  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q + PH_W'(1);
    hold_full_d  = hold_full_q;
    hold_rw_d    = hold_rw_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    cur_req_d    = cur_req_q;
    cur_rw_d     = cur_rw_q;
    cur_addr_d   = cur_addr_q;
    cur_wdata_d  = cur_wdata_q;
    m2_d         = m2_q;
    romsel_d     = romsel_q;
    bus_rw_d     = bus_rw_q;
    bus_addr_d   = bus_addr_q;
    dout_d       = dout_q;
    oe_d         = oe_q;
    rsp_v_d      = 1'b0;
    rdata_d      = rdata_q;

    accept   = req_valid & ~hold_full_q;
    low0     = (state_q == ST_LOW)  && (ph_q == '0);
    low_last = (state_q == ST_LOW)  && (ph_q == LOW_LAST);
    boundary = (state_q == ST_HIGH) && (ph_q == HIGH_LAST);

    if (boundary) begin
      state_d = ST_LOW;
      ph_d    = '0;
    end else if (low_last) begin
      state_d = ST_HIGH;
      ph_d    = '0;
    end

    // Previous address/data are held through LOW ph=0, then the new cycle takes the bus
    if (low0) begin
      bus_addr_d = cur_addr_q;
      bus_rw_d   = cur_rw_q;
      oe_d       = ~cur_rw_q;
      dout_d     = cur_rw_q ? 8'h00 : cur_wdata_q;
    end

    if (low_last) begin
      m2_d     = 1'b1;
      romsel_d = ~bus_addr_q[15];
    end

    if (boundary) begin
      m2_d     = 1'b0;
      romsel_d = 1'b1;
      if (cur_req_q) begin
        rsp_v_d = 1'b1;
        rdata_d = cur_rw_q ? cpu_data_in : 8'h00;
      end
      if (hold_full_q) begin
        cur_req_d   = 1'b1;
        cur_rw_d    = hold_rw_q;
        cur_addr_d  = hold_addr_q;
        cur_wdata_d = hold_wdata_q;
        hold_full_d = 1'b0;
      end else if (accept) begin
        cur_req_d   = 1'b1;
        cur_rw_d    = req_rw;
        cur_addr_d  = req_addr;
        cur_wdata_d = req_wdata;
      end else begin
        cur_req_d   = 1'b0;
        cur_rw_d    = 1'b1;
        cur_addr_d  = 16'h0000;
        cur_wdata_d = 8'h00;
      end
    end else if (accept) begin
      hold_full_d  = 1'b1;
      hold_rw_d    = req_rw;
      hold_addr_d  = req_addr;
      hold_wdata_d = req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LOW;
      ph_q         <= '0;
      hold_full_q  <= 1'b0;
      hold_rw_q    <= 1'b1;
      hold_addr_q  <= 16'h0000;
      hold_wdata_q <= 8'h00;
      cur_req_q    <= 1'b0;
      cur_rw_q     <= 1'b1;
      cur_addr_q   <= 16'h0000;
      cur_wdata_q  <= 8'h00;
      m2_q         <= 1'b0;
      romsel_q     <= 1'b1;
      bus_rw_q     <= 1'b1;
      bus_addr_q   <= 16'h0000;
      dout_q       <= 8'h00;
      oe_q         <= 1'b0;
      rsp_v_q      <= 1'b0;
      rdata_q      <= 8'h00;
      irq_s1_q     <= 1'b0;
      irq_s2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      hold_full_q  <= hold_full_d;
      hold_rw_q    <= hold_rw_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      cur_req_q    <= cur_req_d;
      cur_rw_q     <= cur_rw_d;
      cur_addr_q   <= cur_addr_d;
      cur_wdata_q  <= cur_wdata_d;
      m2_q         <= m2_d;
      romsel_q     <= romsel_d;
      bus_rw_q     <= bus_rw_d;
      bus_addr_q   <= bus_addr_d;
      dout_q       <= dout_d;
      oe_q         <= oe_d;
      rsp_v_q      <= rsp_v_d;
      rdata_q      <= rdata_d;
      irq_s1_q     <= ~irq_n;
      irq_s2_q     <= irq_s1_q;
    end
  end

  assign req_ready    = ~hold_full_q;
  assign rsp_valid    = rsp_v_q;
  assign rsp_rdata    = rdata_q;
  assign m2           = m2_q;
  assign romsel       = romsel_q;
  assign cpu_rw       = bus_rw_q;
  assign cpu_addr     = bus_addr_q[14:0];
  assign cpu_data_out = dout_q;
  assign cpu_data_oe  = oe_q;
  assign irq_pending  = irq_s2_q;
endmodule

// File: tb/tb_nes_cpu_bus_initiator.sv
// Directed bench for nes_cpu_bus_initiator at default timing (5 low / 7 high);
// k counts clks since reset release so k%12 is the expected phase position.
module tb_nes_cpu_bus_initiator;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_rw = 1'b1;
  logic [15:0] req_addr = 16'h0;
  logic [7:0]  req_wdata = 8'h0, cpu_data_in = 8'h0;
  logic        irq_n = 1'b1;
  logic        req_ready, rsp_valid, m2, romsel, cpu_rw, cpu_data_oe, irq_pending;
  logic [7:0]  rsp_rdata, cpu_data_out;
  logic [14:0] cpu_addr;

  int checks = 0, errors = 0;
  int k, t, base, pulses, ci, cyc, hi, first;
  logic rdy, e_rdy;

  nes_cpu_bus_initiator dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .m2(m2), .romsel(romsel),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in), .irq_n(irq_n),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) if (rst) k <= 0; else k <= k + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 14; i++) begin
      tick();
      if (k % 12 == p) return;
    end
    chk("wait_pos_timeout", k % 12, p);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_m2"}, m2, 0);
    chk({tag, "_romsel"}, romsel, 1);
    chk({tag, "_rw"}, cpu_rw, 1);
    chk({tag, "_addr"}, cpu_addr, 0);
    chk({tag, "_oe"}, cpu_data_oe, 0);
    chk({tag, "_dout"}, cpu_data_out, 0);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_rsp_v"}, rsp_valid, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_irq"}, irq_pending, 0);
  endtask

  initial begin
    repeat (2) smp();
    check_reset("por");
    rst = 1'b0;

    // idle: three bus cycles of reads at $0000, no responses
    for (int n = 0; n < 36; n++) begin
      smp();
      chk("idle_m2", m2, (k % 12) >= 5);
      chk("idle_addr", cpu_addr, 0);
      chk("idle_rw", cpu_rw, 1);
      chk("idle_romsel", romsel, 1);
      chk("idle_rsp_v", rsp_valid, 0);
    end

    // ROM read $8123, data $A5 driven only during the read's HIGH phase
    wait_pos(2);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h8123;
    base = k + 10;
    smp(); chk("rd_rdy_pre", req_ready, 1);
    tick(); req_valid = 1'b0;
    smp(); chk("rd_held", req_ready, 0);
    for (int n = 0; n < 40; n++) begin
      tick();
      t = k - base;
      cpu_data_in = (t >= 5 && t <= 11) ? 8'hA5 : 8'h5A;
      smp();
      if (t >= 0) begin
        chk("rd_m2", m2, (t % 12) >= 5);
        chk("rd_addr", cpu_addr, (t >= 1 && t <= 12) ? 15'h0123 : 15'h0);
        chk("rd_rw", cpu_rw, 1);
        chk("rd_romsel", romsel, !(t >= 5 && t <= 11));
        chk("rd_rsp_v", rsp_valid, t == 12);
        if (t >= 12) chk("rd_rdata", rsp_rdata, 8'hA5);
      end
      if (t == 13) break;
    end

    // RAM-area write $6000 <- $3C
    wait_pos(2);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h6000; req_wdata = 8'h3C;
    base = k + 10;
    tick(); req_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      t = k - base;
      smp();
      if (t >= 0) begin
        chk("wr_rw", cpu_rw, !(t >= 1 && t <= 12));
        chk("wr_addr", cpu_addr, (t >= 1 && t <= 12) ? 15'h6000 : 15'h0);
        chk("wr_oe", cpu_data_oe, t >= 1 && t <= 12);
        if (t >= 1 && t <= 12) chk("wr_dout", cpu_data_out, 8'h3C);
        chk("wr_romsel", romsel, 1);
        chk("wr_m2", m2, (t % 12) >= 5);
        chk("wr_rsp_v", rsp_valid, t == 12);
        if (t == 12) chk("wr_rdata", rsp_rdata, 8'h00);
      end
      if (t == 13) break;
    end

    // back-to-back writes $8000..$8003 with req_valid held
    wait_pos(2);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h8000; req_wdata = 8'h10;
    base = k + 10;
    pulses = 0;
    for (int n = 0; n < 60; n++) begin
      smp();
      t = k - base;
      rdy = req_ready;
      if (rsp_valid) pulses++;
      if (t < 0) begin ci = -1; cyc = -1; end
      else begin ci = t / 12; cyc = (t % 12 == 0) ? ci - 1 : ci; end
      e_rdy = (t < 0) ? (t == -10) : ((t >= 36) ? 1'b1 : (t % 12 == 0));
      chk("b2b_rdy", req_ready, e_rdy);
      chk("b2b_addr", cpu_addr, (cyc >= 0 && cyc <= 3) ? 15'(cyc) : 15'h0);
      chk("b2b_rw", cpu_rw, !(cyc >= 0 && cyc <= 3));
      chk("b2b_oe", cpu_data_oe, cyc >= 0 && cyc <= 3);
      if (cyc >= 0 && cyc <= 3) chk("b2b_dout", cpu_data_out, 8'h10 + 8'(cyc));
      chk("b2b_romsel", romsel, !(ci >= 0 && ci <= 3 && (t % 12) >= 5));
      chk("b2b_rsp_v", rsp_valid, t >= 12 && t <= 48 && (t % 12 == 0));
      if (t >= 12 && t <= 48 && (t % 12 == 0)) chk("b2b_rdata", rsp_rdata, 0);
      tick();
      if (req_valid && rdy) begin
        if (req_addr == 16'h8003) req_valid = 1'b0;
        else begin req_addr = req_addr + 16'h1; req_wdata = req_wdata + 8'h1; end
      end
    end
    chk("b2b_pulses", pulses, 4);

    // bypass: read $C010 presented on the boundary clk
    wait_pos(11);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'hC010;
    base = k + 1;
    smp(); chk("byp_rdy_pre", req_ready, 1);
    tick(); req_valid = 1'b0;
    t = k - base;
    for (int n = 0; n < 14; n++) begin
      t = k - base;
      cpu_data_in = (t >= 5 && t <= 11) ? 8'h77 : 8'h00;
      smp();
      chk("byp_rdy", req_ready, 1);
      chk("byp_addr", cpu_addr, (t >= 1 && t <= 12) ? 15'h4010 : 15'h0);
      chk("byp_romsel", romsel, !(t >= 5 && t <= 11));
      chk("byp_rsp_v", rsp_valid, t == 12);
      if (t == 12) chk("byp_rdata", rsp_rdata, 8'h77);
      tick();
    end

    // irq_n low for 10 clks
    smp(); chk("irq_idle", irq_pending, 0);
    tick();
    hi = 0; first = -1;
    for (int j = 0; j < 16; j++) begin
      irq_n = (j < 10) ? 1'b0 : 1'b1;
      smp();
      if (irq_pending) begin hi++; if (first < 0) first = j; end
      tick();
    end
    chk("irq_width", hi, 10);
    chk("irq_delay", (first >= 2 && first <= 3), 1);

    // reset mid-HIGH with one transaction in flight and one held
    wait_pos(2);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h8123;
    tick(); req_valid = 1'b0;
    wait_pos(2);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h6001; req_wdata = 8'h99;
    tick(); req_valid = 1'b0;
    smp(); chk("mr_held", req_ready, 0);
    wait_pos(7);
    #2 rst = 1'b1;
    #1 check_reset("mr");
    smp(); rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      smp();
      chk("mr_rsp_v", rsp_valid, 0);
      chk("mr_addr", cpu_addr, 0);
      chk("mr_rw", cpu_rw, 1);
      chk("mr_rdy", req_ready, 1);
      chk("mr_m2", m2, (k % 12) >= 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nes_cpu_bus_initiator.md
# nes_cpu_bus_initiator

Console-side generator of Famicom/NES CPU bus cycles, the initiator that drives the cartridge's `m2`/`romsel`/`cpu_rw_in`/`cpu_addr_in`/`cpu_data_in` pins. It accepts single-byte read/write requests over a valid/ready port, buffers one request, and runs continuous M2 bus cycles, inserting idle reads when no request is pending. Read data is sampled at the M2 falling edge and returned as a response pulse. The block sits in the bring-up and verification harness and the cartridge dumper/programmer that exercise the multicart mapper logic.

## Interface
- `M2_LOW`, default 5: clk cycles per M2-low (phi1) phase; legal range ≥2.
- `M2_HIGH`, default 7: clk cycles per M2-high (phi2) phase; legal range ≥2.
- `clk` in 1: single system clock; every register is clocked on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: holding register empty; a request is accepted when `req_valid & req_ready`.
- `req_rw` in 1: 1 = read, 0 = write.
- `req_addr` in 16: CPU address.
- `req_wdata` in 8: write data.
- `rsp_valid` out 1: one-clk pulse when a requested transaction completes; idle cycles never pulse.
- `rsp_rdata` out 8: sampled read data; 0 for writes.
- `m2` out 1: M2 clock to the cartridge.
- `romsel` out 1: active-low, equals ~(A15 & M2).
- `cpu_rw` out 1: 1 = read.
- `cpu_addr` out 15: A14..A0.
- `cpu_data_out` out 8: write data.
- `cpu_data_oe` out 1: data bus drive enable.
- `cpu_data_in` in 8: data bus sampled value.
- `irq_n` in 1: cartridge IRQ, active-low, asynchronous.
- `irq_pending` out 1: `irq_n` inverted and synchronized through 2 flops.

## Operation
- Two-state phase FSM, LOW and HIGH, with a phase counter `ph` (0..M2_LOW-1 in LOW, 0..M2_HIGH-1 in HIGH). M2 runs continuously and never stalls.
- **Boundary** is the last clk of HIGH (`ph = M2_HIGH-1`). On the boundary edge:
  - `m2` goes to 0 and `romsel` goes to 1.
  - `cpu_data_in` is captured, if the current cycle is a requested read.
  - The next cycle's transaction is selected.
- **Next transaction selection**, in priority order:
  1. Holding register, if full; the register is then cleared.
  2. Bypass, if the holding register is empty and a request is accepted on this same clk; the request goes straight to the bus and the holding register stays empty.
  3. Otherwise an idle cycle: read at $0000, no response.
- **Accept outside the boundary:** a request accepted on any other clk is written to the holding register, and `req_ready` falls on the next clk.
- **Address hold:** the selected transaction's address and rw drive the bus at the edge ending LOW `ph=0`. During LOW `ph=0`, the previous address, rw and data stay on the bus.
- **Write data:** `cpu_data_oe` is 1 from the edge ending LOW `ph=0` through the end of LOW `ph=0` of the following cycle. `cpu_data_out` holds the write data for that whole window.
- **Entering HIGH:** at the edge entering HIGH, `m2` goes to 1 and `romsel` goes to `~addr[15]`.
- **Response:** `rsp_valid` pulses on the clk following the boundary of a requested transaction. `rsp_rdata` holds until the next pulse.

## Timing
- **Reset values:**
  - `m2`=0, `romsel`=1, `cpu_rw`=1, `cpu_addr`=0, `cpu_data_oe`=0, `cpu_data_out`=0.
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `irq_pending`=0.
  - FSM in LOW with `ph`=0, holding register empty.
- **Reset mid-operation:** any in-flight or held transaction is dropped with no response. The first cycle after release is an idle cycle.
- **Cycle length:** bus cycle = M2_LOW+M2_HIGH clks (12 by default), with `m2` high for M2_HIGH clks.
- **Latency, bypass accept at boundary:** address on the bus 1 clk later, `m2` rises M2_LOW clks after the boundary, `rsp_valid` 1 clk after the following boundary.
- **Throughput:** one transaction per bus cycle. The holding register plus bypass sustain back-to-back requests.
- **`irq_pending` latency:** 2–3 clks after `irq_n` changes.

## Test plan
- **Reset.** Assert `rst` mid-HIGH with a request held -> all outputs at reset values, `req_ready`=1; after release there is no `rsp_valid` for the dropped request.
- **Idle.** No requests for 3 bus cycles -> `m2` period 12 clks (5 low, 7 high), `cpu_addr`=0, `cpu_rw`=1, `romsel` constantly 1, `rsp_valid` never asserted.
- **ROM read.** Read $8123 with the bench driving `cpu_data_in`=$A5 during HIGH:
  - `cpu_addr`=$0123 and `romsel`=0 exactly while `m2`=1.
  - `rsp_valid` pulses once with `rsp_rdata`=$A5.
- **RAM-area write.** Write $6000 with data $3C:
  - `cpu_rw`=0, `romsel` stays 1, `cpu_data_out`=$3C.
  - `cpu_data_oe` stays high 1 clk past the falling edge of `m2`.
  - `rsp_valid` pulses with `rsp_rdata`=0.
- **Back-to-back.** Hold `req_valid` for 4 writes to $8000..$8003:
  - 4 consecutive bus cycles with no idle cycle between them.
  - `req_ready` low while the holding register is full.
  - Exactly 4 `rsp_valid` pulses, in order.
- **Bypass and IRQ.**
  - Request presented exactly on the boundary clk with an empty holding register -> the new address appears 1 clk later and `req_ready` never drops.
  - Pulse `irq_n` low for 10 clks -> `irq_pending` high for 10 clks, delayed by 2–3 clks.
